block_raster_reader: RTL and testbench

BLOCK_RASTER_READER -- requirements
Module: block_raster_reader

---
 rtl/block_raster_reader_if.sv | 30 +++
 rtl/block_raster_reader.sv | 219 +++++++++++++++++++++
 tb/tb_block_raster_reader.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_raster_reader_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | block_raster_reader_if : AXI read address/data handshake bundle           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface block_raster_reader_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic                  rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rlast
    );
endinterface
`default_nettype wire

// File: rtl/block_raster_reader.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | block_raster_reader : walks a multi-plane frame block by block, issuing   |
// | one AXI INCR burst per block row.                     Rev 1.0             |
// +--------------------------------------------------------------------------+
module block_raster_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 8,
    parameter int NUM_CH     = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  frame_ready,
    input  wire logic [15:0]           frame_height,
    input  wire logic [15:0]           frame_width,
    input  wire logic [ADDR_WIDTH-1:0] base_addr_in,
    input  wire logic [ADDR_WIDTH-1:0] plane_stride,
    input  wire logic                  consumer_done,
    block_raster_reader_if.master      axi,
    output logic                       pix_valid,
    output logic                       start_of_block,
    output logic                       start_of_frame,
    output logic [1:0]                 ch_idx,
    output logic                       frame_done,
    output logic [ADDR_WIDTH-1:0]      base_addr_out,
    output logic                       busy,
    output logic                       len_err
);
    localparam int                    BPB        = DATA_WIDTH / 8;
    localparam int                    PY_W       = $clog2(BLOCK_SIZE);
    localparam logic [PY_W-1:0]       LAST_PY    = PY_W'(BLOCK_SIZE - 1);
    localparam logic [PY_W:0]         LAST_BEAT  = (PY_W+1)'(BLOCK_SIZE - 1);
    localparam logic [1:0]            LAST_CH    = 2'(NUM_CH - 1);
    localparam logic [ADDR_WIDTH-1:0] C_BLK_STEP = ADDR_WIDTH'(BLOCK_SIZE * BPB);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, blk_q, blk_d, rowb_q, rowb_d, plane_q, plane_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, stride_q, stride_d, line_q, line_d;
    logic [15:0]           rows_q, rows_d, cols_q, cols_d, brow_q, brow_d, bcol_q, bcol_d;
    logic [PY_W-1:0]       py_q, py_d;
    logic [PY_W:0]         beat_q, beat_d;
    logic [1:0]            ch_q, ch_d;
    logic                  len_err_q, len_err_d, frame_done_q, frame_done_d;

    logic                  w_rready, w_pix;
    logic [15:0]           w_rows, w_cols;
    logic [ADDR_WIDTH-1:0] w_line;

    assign w_rready = (state_q == S_DATA);
    assign w_pix    = axi.rvalid & w_rready;
    assign w_rows   = frame_height >> PY_W;
    assign w_cols   = frame_width >> PY_W;
    assign w_line   = ADDR_WIDTH'(frame_width) * ADDR_WIDTH'(BPB);

    assign axi.arvalid = (state_q == S_ADDR);
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'(BLOCK_SIZE - 1);
    assign axi.arsize  = 3'($clog2(BPB));
    assign axi.arburst = 2'b01;
    assign axi.rready  = w_rready;

    assign pix_valid      = w_pix;
    assign start_of_block = w_pix && (beat_q == '0) && (py_q == '0);
    assign start_of_frame = start_of_block && (ch_q == 2'd0) && (brow_q == 16'd0) && (bcol_q == 16'd0);
    assign ch_idx         = ch_q;
    assign frame_done     = frame_done_q;
    assign base_addr_out  = base_q;
    assign busy           = (state_q != S_IDLE);
    assign len_err        = len_err_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        blk_d        = blk_q;
        rowb_d       = rowb_q;
        plane_d      = plane_q;
        base_d       = base_q;
        stride_d     = stride_q;
        line_d       = line_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        brow_d       = brow_q;
        bcol_d       = bcol_q;
        py_d         = py_q;
        beat_d       = beat_q;
        ch_d         = ch_q;
        len_err_d    = len_err_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_ready) begin
                    base_d    = base_addr_in;
                    stride_d  = plane_stride;
                    line_d    = w_line;
                    rows_d    = w_rows;
                    cols_d    = w_cols;
                    addr_d    = base_addr_in;
                    blk_d     = base_addr_in;
                    rowb_d    = base_addr_in;
                    plane_d   = base_addr_in;
                    brow_d    = '0;
                    bcol_d    = '0;
                    py_d      = '0;
                    beat_d    = '0;
                    ch_d      = '0;
                    len_err_d = 1'b0;
                    state_d   = (w_rows == 16'd0 || w_cols == 16'd0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                if (axi.arready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_pix) begin
                    // Saturate so an over-long burst cannot alias back to beat 0.
                    if (beat_q != '1) begin
                        beat_d = beat_q + (PY_W+1)'(1);
                    end
                    if (beat_q == LAST_BEAT && !axi.rlast) begin
                        len_err_d = 1'b1;
                    end
                    if (axi.rlast) begin
                        if (beat_q != LAST_BEAT) begin
                            len_err_d = 1'b1;
                        end
                        beat_d  = '0;
                        state_d = S_ADDR;
                        // Running bases replace a full address multiply per burst.
                        if (py_q != LAST_PY) begin
                            py_d   = py_q + PY_W'(1);
                            addr_d = addr_q + line_q;
                        end else begin
                            py_d = '0;
                            if (bcol_q != cols_q - 16'd1) begin
                                bcol_d = bcol_q + 16'd1;
                                blk_d  = blk_q + C_BLK_STEP;
                                addr_d = blk_d;
                            end else begin
                                bcol_d = '0;
                                if (brow_q != rows_q - 16'd1) begin
                                    brow_d = brow_q + 16'd1;
                                    rowb_d = rowb_q + (line_q << PY_W);
                                    blk_d  = rowb_d;
                                    addr_d = rowb_d;
                                end else begin
                                    brow_d = '0;
                                    if (ch_q != LAST_CH) begin
                                        ch_d    = ch_q + 2'd1;
                                        plane_d = plane_q + stride_q;
                                        rowb_d  = plane_d;
                                        blk_d   = plane_d;
                                        addr_d  = plane_d;
                                    end else begin
                                        state_d = S_DONE;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                if (consumer_done) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            blk_q        <= '0;
            rowb_q       <= '0;
            plane_q      <= '0;
            base_q       <= '0;
            stride_q     <= '0;
            line_q       <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            brow_q       <= '0;
            bcol_q       <= '0;
            py_q         <= '0;
            beat_q       <= '0;
            ch_q         <= '0;
            len_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            blk_q        <= blk_d;
            rowb_q       <= rowb_d;
            plane_q      <= plane_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            line_q       <= line_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            brow_q       <= brow_d;
            bcol_q       <= bcol_d;
            py_q         <= py_d;
            beat_q       <= beat_d;
            ch_q         <= ch_d;
            len_err_q    <= len_err_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_block_raster_reader.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_block_raster_reader : randomized AXI slave, frame-level reference     |
// | model and scoreboard for block_raster_reader.          Rev 1.0            |
// +--------------------------------------------------------------------------+
module tb_block_raster_reader;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BS  = 8;
    localparam int NCH = 3;
    localparam int BPB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_ready = 1'b0;
    logic [15:0]   frame_height = '0, frame_width = '0;
    logic [AW-1:0] base_addr_in = '0, plane_stride = '0;
    logic          consumer_done = 1'b0;
    logic          pix_valid, start_of_block, start_of_frame, frame_done, busy, len_err;
    logic [1:0]    ch_idx;
    logic [AW-1:0] base_addr_out;

    block_raster_reader_if #(.ADDR_WIDTH(AW)) axi ();

    block_raster_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .NUM_CH(NCH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready),
        .frame_height(frame_height), .frame_width(frame_width),
        .base_addr_in(base_addr_in), .plane_stride(plane_stride),
        .consumer_done(consumer_done), .axi(axi),
        .pix_valid(pix_valid), .start_of_block(start_of_block),
        .start_of_frame(start_of_frame), .ch_idx(ch_idx), .frame_done(frame_done),
        .base_addr_out(base_addr_out), .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ch;
        bit          sob;
        bit          sof;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0, n_err = 0;
    int   exp_bursts = 0, exp_len_err = 0, fd_cnt = 0, f_bursts = 0;
    int   pending = 0, sbeat = 0, burst_total = 0, ar_seen = 0, ar_delay = 0, err_abs = -1;
    bit   short_cur = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Frame rules: planes, then block rows, block cols, pixel rows inside a block.
    task automatic push_model(input int h, input int w, input logic [31:0] base, input logic [31:0] stride);
        int rows = h / BS;
        int cols = w / BS;
        for (int c = 0; c < NCH; c++)
            for (int br = 0; br < rows; br++)
                for (int bc = 0; bc < cols; bc++)
                    for (int py = 0; py < BS; py++) begin
                        exp_t e;
                        e.addr = base + c * stride + 32'(((br * BS + py) * w + bc * BS) * BPB);
                        e.ch   = c;
                        e.sob  = (py == 0);
                        e.sof  = (py == 0) && (c == 0) && (br == 0) && (bc == 0);
                        exp_q.push_back(e);
                    end
        exp_bursts = NCH * rows * cols * BS;
    endtask

    // AXI read slave: programmable arready delay, random rvalid gaps, optional short burst.
    initial begin : slave
        bit ar_hs, r_hs;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs = axi.arvalid && axi.arready;
            r_hs  = axi.rvalid && axi.rready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pending = 0; sbeat = 0; ar_seen = 0;
                axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
            end else begin
                if (ar_hs) begin
                    short_cur = (burst_total == err_abs);
                    burst_total++;
                    pending++;
                    ar_seen = 0;
                    axi.arready = 1'b0;
                end
                if (r_hs) begin
                    if (axi.rlast) begin
                        pending--;
                        sbeat = 0;
                    end else begin
                        sbeat++;
                    end
                end
                if (axi.arvalid && !axi.arready) begin
                    if (ar_seen >= ar_delay) axi.arready = 1'b1;
                    else ar_seen++;
                end
                if (pending > 0) begin
                    axi.rvalid = ($urandom_range(3) != 0);
                    axi.rlast  = axi.rvalid && (sbeat == (short_cur ? 5 : BS - 1));
                end else begin
                    axi.rvalid = ($urandom_range(3) == 0);
                    axi.rlast  = 1'($urandom_range(1));
                end
            end
        end
    end

    // Monitor / scoreboard
    exp_t        cur_e;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_wait = 1'b0;
            f_bursts  = 0;
        end else begin
            if (prev_wait) begin
                chk("ar_hold_valid", axi.arvalid, 1);
                chk("ar_hold_addr", axi.araddr, prev_addr);
            end
            if (axi.arvalid && axi.arready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_ar: araddr 0x%0h issued, no burst required", axi.araddr);
                end else begin
                    cur_e = exp_q.pop_front();
                    chk("araddr", axi.araddr, cur_e.addr);
                    chk("ar_ch_idx", ch_idx, cur_e.ch);
                    f_bursts++;
                end
            end
            prev_wait = axi.arvalid && !axi.arready;
            prev_addr = axi.araddr;
            chk("rready", axi.rready, pending != 0);
            chk("pix_valid", pix_valid, axi.rvalid && pending != 0);
            if (axi.rvalid && pending != 0) begin
                chk("start_of_block", start_of_block, (sbeat == 0) && cur_e.sob);
                chk("start_of_frame", start_of_frame, (sbeat == 0) && cur_e.sof);
                chk("beat_ch_idx", ch_idx, cur_e.ch);
            end
            if (frame_done) begin
                chk("frame_bursts", f_bursts, exp_bursts);
                chk("frame_len_err", len_err, exp_len_err);
                f_bursts = 0;
                fd_cnt++;
            end
        end
    end

    task automatic chk_zero();
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_araddr", axi.araddr, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_sob", start_of_block, 0);
        chk("rst_sof", start_of_frame, 0);
        chk("rst_ch_idx", ch_idx, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_base_out", base_addr_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_arlen", axi.arlen, BS - 1);
        chk("rst_arsize", axi.arsize, 2);
        chk("rst_arburst", axi.arburst, 1);
    endtask

    task automatic wait_fd(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (fd_cnt >= target) return;
        end
        n_vec++; n_err++;
        $display("FAIL %s: frame_done not seen within %0d cycles", name, budget);
    endtask

    task automatic start_frame(input int h, input int w, input logic [31:0] base, input logic [31:0] stride,
                               input int dly, input int errb, input bit cd_early);
        push_model(h, w, base, stride);
        exp_len_err   = (errb >= 0 && errb < exp_bursts) ? 1 : 0;
        err_abs       = (errb < 0) ? -1 : burst_total + errb;
        ar_delay      = dly;
        consumer_done = cd_early;
        @(posedge clk);
        #1;
        frame_height = 16'(h); frame_width = 16'(w);
        base_addr_in = base;   plane_stride = stride;
        frame_ready  = 1'b1;
        @(posedge clk);
        #1;
        frame_ready  = 1'b0;
        frame_height = 16'($urandom); frame_width = 16'($urandom);
        base_addr_in = $urandom;      plane_stride = $urandom;
        chk("start_len_err_clear", len_err, 0);
        chk("start_busy", busy, 1);
        chk("start_base_out", base_addr_out, base);
    endtask

    task automatic run_frame(input int h, input int w, input logic [31:0] base, input logic [31:0] stride,
                             input int dly, input int errb, input bit cd_early);
        int start_cnt = fd_cnt;
        start_frame(h, w, base, stride, dly, errb, cd_early);
        if (!cd_early) begin
            int i;
            for (i = 0; i < 20000; i++) begin
                @(posedge clk);
                #2;
                if (f_bursts == exp_bursts && pending == 0) break;
            end
            if (i == 20000) begin
                n_vec++; n_err++;
                $display("FAIL bursts_timeout: %0d of %0d bursts seen", f_bursts, exp_bursts);
            end
            repeat (3) @(posedge clk);
            #2;
            chk("no_done_before_consumer", fd_cnt, start_cnt);
            chk("busy_in_done", busy, 1);
            consumer_done = 1'b1;
        end
        wait_fd(start_cnt + 1, 20000, "frame_done_wait");
        consumer_done = 1'b0;
    endtask

    initial begin : watchdog
        #900000;
        n_vec++; n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : main
        repeat (3) @(posedge clk);
        #1;
        chk_zero();
        rst_n = 1'b1;

        run_frame(16, 16, 32'h1000, 32'h10000, 0, -1, 1'b0);
        run_frame(8, 8, 32'h4000, 32'h10000, 0, -1, 1'b0);
        run_frame(16, 8, 32'h2000, 32'h10000, 5, -1, 1'b0);
        run_frame(7, 12, 32'h3000, 32'h100, 0, -1, 1'b1);
        run_frame(16, 16, 32'h8000, 32'h10000, 0, 1, 1'b0);
        run_frame(8, 16, 32'h9000, 32'h4000, 1, -1, 1'b0);

        // Reset in the middle of the second burst.
        begin
            int i;
            start_frame(16, 16, 32'hA000, 32'h10000, 0, -1, 1'b0);
            for (i = 0; i < 2000; i++) begin
                @(posedge clk);
                #2;
                if (f_bursts == 2 && sbeat == 3) break;
            end
            if (i == 2000) begin
                n_vec++; n_err++;
                $display("FAIL reset_point_timeout: burst %0d beat %0d", f_bursts, sbeat);
            end
            rst_n = 1'b0;
            #1;
            chk_zero();
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            run_frame(8, 8, 32'hA000, 32'h10000, 0, -1, 1'b0);
        end

        // frame_ready held high: next frame starts one cycle after frame_done.
        begin
            int i;
            push_model(8, 8, 32'hC000, 32'h800);
            push_model(8, 8, 32'hC000, 32'h800);
            exp_len_err = 0; err_abs = -1; ar_delay = 0;
            @(posedge clk);
            #1;
            frame_height = 16'd8; frame_width = 16'd8;
            base_addr_in = 32'hC000; plane_stride = 32'h800;
            consumer_done = 1'b1;
            frame_ready   = 1'b1;
            for (i = 0; i < 5000; i++) begin
                @(negedge clk);
                if (frame_done) break;
            end
            if (i == 5000) begin
                n_vec++; n_err++;
                $display("FAIL held_ready_timeout: no frame_done");
            end
            chk("held_idle_at_done", busy, 0);
            @(negedge clk);
            chk("held_restart", busy, 1);
            frame_ready = 1'b0;
            wait_fd(fd_cnt + 1, 5000, "held_second_frame");
            consumer_done = 1'b0;
        end

        for (int k = 0; k < 5; k++) begin
            run_frame($urandom_range(0, 24), $urandom_range(0, 24), $urandom, $urandom,
                      $urandom_range(0, 3), -1, 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
